ysyx_isram: RTL and testbench
=============================

YSYX_ISRAM -- requirements
Module: ysyx_isram

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; fixed at 32 for word fetch.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit words.
REQ-004 SHALL have parameter MEM_BASE, default 32'h8000_0000, byte address of word 0.
REQ-005 SHALL have parameter LATENCY, default 2, cycles from accept to rvalid; legal range 1..15.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port araddr, input, ADDR_W, fetch byte address.
REQ-009 SHALL have port arvalid, input, 1, read request valid.
REQ-010 SHALL have port arready, output, 1, responder can accept a request.
REQ-011 SHALL have port rdata, output, DATA_W, read data.
REQ-012 SHALL have port rvalid, output, 1, single-cycle read-data-valid pulse; there is no rready.
REQ-013 SHALL have port rresp, output, 2, response code: 00 OKAY, 10 SLVERR (misaligned), 11 DECERR (out of range).
REQ-014 SHALL have port ld_we, input, 1, preload write enable.
REQ-015 SHALL have port ld_idx, input, log2(MEM_DEPTH), preload word index.
REQ-016 SHALL have port ld_wdata, input, 32, preload data.
REQ-017 SHALL have port req_cnt, output, 32, count of completed responses.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-019 SHALL drive arready = 1 only in IDLE with rst low; 0 in BUSY and RESP.
REQ-020 SHALL accept a request in cycle T when state is IDLE and arvalid is 1, and latch araddr into an internal register.
REQ-021 SHALL, for LATENCY = 1, go IDLE->RESP on accept; for LATENCY >= 2, go IDLE->BUSY and load a down-counter with LATENCY-2.
REQ-022 SHALL, in BUSY, decrement the counter each cycle and go to RESP in the cycle after the counter reads 0.
REQ-023 SHALL assert rvalid = 1 only in RESP, i.e. exactly in cycle T+LATENCY, for exactly one cycle; RESP SHALL always go to IDLE next.
REQ-024 SHALL register rdata and rresp on the transition into RESP and hold them stable until the next transition into RESP.
REQ-025 SHALL compute index = (addr - MEM_BASE) >> 2 using ADDR_W-bit unsigned wrap-around arithmetic.
REQ-026 SHALL, when addr[1:0] != 0, set rresp to 10 and rdata to 0; this check has priority over the range check.
REQ-027 SHALL, when aligned and index >= MEM_DEPTH (including addr < MEM_BASE via wrap), set rresp to 11 and rdata to 0.
REQ-028 SHALL otherwise set rresp to 00 and rdata to mem[index].
REQ-029 SHALL NOT abort an accepted request when arvalid falls before rvalid; the response is still delivered.
REQ-030 SHALL permit a new accept in the IDLE cycle immediately after RESP when arvalid is held high; back-to-back throughput is one request per LATENCY+1 cycles.
REQ-031 SHALL write ld_wdata to mem[ld_idx] on any clock edge with ld_we = 1, in any state.
REQ-032 SHALL make a preload write to the pending index visible only if it occurs in a cycle strictly before the transition into RESP; a write on the same edge as that transition returns the old word.
REQ-033 SHALL increment req_cnt by 1 in each RESP cycle, wrapping from 32'hFFFF_FFFF to 0, including error responses.

Reset
REQ-034 SHALL, on a clock edge with rst = 1, force state IDLE, counter 0, rvalid 0, rdata 0, rresp 00, req_cnt 0, and keep arready 0 while rst is high.
REQ-035 SHALL, when rst is asserted in BUSY or RESP, drop the pending request with no rvalid afterwards.
REQ-036 SHALL NOT clear memory contents on reset, and SHALL still honour ld_we while rst is high.

Verification
REQ-037 SHALL verify single fetch: preload mem[0] = 32'h0000_0413, LATENCY = 2, arvalid with araddr 32'h8000_0000 accepted at T -> rvalid only at T+2, rdata 32'h0000_0413, rresp 00, req_cnt 1.
REQ-038 SHALL verify back-to-back fetch: arvalid held high across 0x8000_0000 then 0x8000_0004 -> accepts at T and T+3, rvalid at T+2 and T+5, correct words each time.
REQ-039 SHALL verify errors: araddr 0x8000_0002 -> rresp 10, rdata 0; araddr 0x7FFF_FFFC -> rresp 11; araddr MEM_BASE+4*MEM_DEPTH -> rresp 11.
REQ-040 SHALL verify abort-free delivery: arvalid deasserted at T+1 -> rvalid still at T+LATENCY.
REQ-041 SHALL verify reset mid-operation: rst asserted at T+1 in BUSY -> no rvalid ever; arready 1 in the first cycle after rst falls; memory word unchanged.
REQ-042 SHALL verify preload race: ld_we to the pending index at the same edge as the BUSY->RESP transition -> old data returned; the same write one cycle earlier -> new data returned.

Source files
------------

// File: rtl/ysyx_isram.sv
// ============================================================================
//  Module   : ysyx_isram
//  Brief    : Instruction SRAM responder with fixed fetch latency and preload port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_isram #(
    parameter int                MEM_DEPTH = 1024,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE  = ADDR_W'(32'h8000_0000),
    parameter int                LATENCY   = 2,
    parameter int                IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [1:0]        rresp,
    input  logic              ld_we,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       req_cnt
);

    localparam logic [ADDR_W-1:0] c_depth    = ADDR_W'(MEM_DEPTH);
    localparam logic [3:0]        c_cnt_load = 4'(LATENCY - 2);
    localparam logic [1:0]        c_okay     = 2'b00;
    localparam logic [1:0]        c_slverr   = 2'b10;
    localparam logic [1:0]        c_decerr   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rvalid;
    logic [31:0]         r_req_cnt;
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    logic [ADDR_W-1:0]   w_lkup_addr;
    logic [ADDR_W-1:0]   w_offset;
    logic [ADDR_W-1:0]   w_word;
    logic                w_misalign;
    logic                w_oob;
    logic [DATA_W-1:0]   w_mem_word;
    logic [DATA_W-1:0]   w_resp_data;
    logic [1:0]          w_resp_code;

    // With LATENCY == 1 the lookup happens on the accept edge, before r_addr holds the address.
    assign w_lkup_addr = (r_state == S_IDLE) ? araddr : r_addr;
    assign w_offset    = w_lkup_addr - MEM_BASE;
    assign w_word      = w_offset >> 2;
    assign w_misalign  = |w_lkup_addr[1:0];
    assign w_oob       = (w_word >= c_depth);
    assign w_mem_word  = r_mem[w_word[IDX_W-1:0]];

    always_comb begin
        w_resp_data = '0;
        w_resp_code = c_okay;
        if (w_misalign) begin
            w_resp_code = c_slverr;
        end else if (w_oob) begin
            w_resp_code = c_decerr;
        end else begin
            w_resp_data = w_mem_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_okay;
            r_req_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arvalid) begin
                        r_addr <= araddr;
                        if (LATENCY == 1) begin
                            r_state  <= S_RESP;
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_resp_data;
                            r_rresp  <= w_resp_code;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= c_cnt_load;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state  <= S_RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= w_resp_data;
                        r_rresp  <= w_resp_code;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    r_rvalid  <= 1'b0;
                    r_req_cnt <= r_req_cnt + 32'd1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_rvalid <= 1'b0;
                end
            endcase
        end
    end

    // Preload is independent of the FSM and of reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            r_mem[ld_idx] <= ld_wdata;
        end
    end

    assign arready = (r_state == S_IDLE) && !rst;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign req_cnt = r_req_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_isram.sv
// ============================================================================
//  Module   : tb_ysyx_isram
//  Brief    : Cycle-stepped bench for ysyx_isram against a transaction-level model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_isram;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic [1:0]  rresp;
    logic        ld_we = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_wdata = '0;
    logic [31:0] req_cnt;

    always #5 clk = ~clk;

    ysyx_isram #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MEM_DEPTH(DEPTH),
        .MEM_BASE (BASE),
        .LATENCY  (LAT)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rresp   (rresp),
        .ld_we   (ld_we),
        .ld_idx  (ld_idx),
        .ld_wdata(ld_wdata),
        .req_cnt (req_cnt)
    );

    // Reference model: a pending fetch is just (address, cycle its data is due).
    logic [31:0] m_mem [DEPTH];
    bit          m_pend = 0;
    bit          m_live = 0;
    int          m_due  = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic [31:0] m_cnt = '0;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rv = 0;
    int          last_rv_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic [1:0]  last_rresp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic ref_resp(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] idx;
        idx = (a - BASE) >> 2;
        if (a[1:0] != 2'b00) begin
            d = '0; r = 2'b10;
        end else if (idx >= 32'(DEPTH)) begin
            d = '0; r = 2'b11;
        end else begin
            d = m_mem[idx[9:0]]; r = 2'b00;
        end
    endtask

    // One clock cycle: check the current outputs, then drive inputs for the next edge
    // and predict what that edge does.
    task automatic step(input bit t_rst, input bit t_av, input logic [31:0] t_addr,
                        input bit t_we, input logic [9:0] t_idx, input logic [31:0] t_wd);
        @(negedge clk);
        if (m_live) begin
            chk("arready", 32'(arready), 32'(!rst && !m_pend));
            chk("rvalid",  32'(rvalid),  32'(m_pend && (m_due == cyc)));
            chk("rdata",   rdata,        m_rdata);
            chk("rresp",   32'(rresp),   32'(m_rresp));
            chk("req_cnt", req_cnt,      m_cnt);
        end
        if (rvalid === 1'b1) begin
            n_rv++;
            last_rv_cyc = cyc;
            last_rdata  = rdata;
            last_rresp  = rresp;
        end
        rst      = t_rst;
        arvalid  = t_av;
        araddr   = t_addr;
        ld_we    = t_we;
        ld_idx   = t_idx;
        ld_wdata = t_wd;
        if (t_rst) begin
            m_pend  = 0;
            m_rdata = '0;
            m_rresp = '0;
            m_cnt   = '0;
            m_live  = 1;
        end else if (m_live) begin
            if (m_pend && m_due == cyc) begin
                m_pend = 0;
                m_cnt  = m_cnt + 32'd1;
            end else if (!m_pend && t_av) begin
                m_pend = 1;
                m_due  = cyc + LAT;
                m_addr = t_addr;
            end
            if (m_pend && m_due == cyc + 1) ref_resp(m_addr, m_rdata, m_rresp);
        end
        if (t_we) m_mem[t_idx] = t_wd;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(0, 1, a, 0, '0, '0);
        idle(LAT + 1);
    endtask

    initial begin
        int          t0;
        int          n0;
        logic [31:0] old_w;
        logic [31:0] new_w;
        logic [31:0] a;
        logic [9:0]  wi;

        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // Preload under reset: memory writes must still land while rst is high.
        step(1, 0, '0, 1, 10'd0, 32'h0000_0413);
        for (int i = 1; i < 16; i++) step(1, 0, '0, 1, 10'(i), $urandom);
        step(1, 0, '0, 1, 10'(DEPTH - 1), $urandom);
        idle(2);

        t0 = cyc;
        fetch(BASE);
        chk("single_rdata", last_rdata, 32'h0000_0413);
        chk("single_rresp", 32'(last_rresp), 32'd0);
        chk("single_lat", 32'(last_rv_cyc - t0), 32'(LAT));
        chk("single_cnt", req_cnt, 32'd1);

        t0 = cyc;
        n0 = n_rv;
        for (int i = 0; i < 3; i++) step(0, 1, BASE, 0, '0, '0);
        for (int i = 0; i < 3; i++) step(0, 1, BASE + 32'd4, 0, '0, '0);
        idle(3);
        chk("b2b_count", 32'(n_rv - n0), 32'd2);
        chk("b2b_second_lat", 32'(last_rv_cyc - t0), 32'(2 * LAT + 1));
        chk("b2b_second_data", last_rdata, m_mem[1]);

        fetch(32'h8000_0002);
        chk("misalign_rresp", 32'(last_rresp), 32'h2);
        chk("misalign_rdata", last_rdata, 32'h0);
        fetch(32'h7FFF_FFFC);
        chk("below_base_rresp", 32'(last_rresp), 32'h3);
        fetch(BASE + 32'(4 * DEPTH));
        chk("past_end_rresp", 32'(last_rresp), 32'h3);
        fetch(32'h7FFF_FFFE);
        chk("misalign_priority", 32'(last_rresp), 32'h2);
        fetch(BASE + 32'(4 * (DEPTH - 1)));
        chk("last_word_rresp", 32'(last_rresp), 32'h0);

        n0 = n_rv;
        t0 = cyc;
        step(0, 1, BASE + 32'd8, 0, '0, '0);
        idle(4);
        chk("abort_free_count", 32'(n_rv - n0), 32'd1);
        chk("abort_free_lat", 32'(last_rv_cyc - t0), 32'(LAT));

        old_w = m_mem[3];
        n0 = n_rv;
        step(0, 1, BASE + 32'd12, 0, '0, '0);
        step(1, 0, '0, 0, '0, '0);
        step(0, 0, '0, 0, '0, '0);
        #1;
        chk("rst_arready", 32'(arready), 32'd1);
        idle(5);
        chk("rst_no_rvalid", 32'(n_rv - n0), 32'd0);
        fetch(BASE + 32'd12);
        chk("rst_mem_kept", last_rdata, old_w);

        old_w = m_mem[5];
        new_w = ~old_w;
        step(0, 1, BASE + 32'd20, 0, '0, '0);
        step(0, 0, '0, 1, 10'd5, new_w);
        idle(3);
        chk("race_same_edge", last_rdata, old_w);
        new_w = new_w ^ 32'h5A5A_0F0F;
        step(0, 1, BASE + 32'd20, 1, 10'd5, new_w);
        idle(4);
        chk("race_earlier", last_rdata, new_w);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = BASE + 32'(4 * $urandom_range(0, 15));
                6:       a = BASE + 32'(4 * (DEPTH - 1));
                7:       a = BASE + 32'($urandom_range(0, 63) | 1);
                8:       a = 32'h7FFF_FF00 + 32'(4 * $urandom_range(0, 63));
                default: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
            endcase
            wi = ($urandom_range(0, 7) == 0) ? 10'(DEPTH - 1) : 10'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, a,
                 $urandom_range(0, 4) == 0, wi, $urandom);
        end
        idle(LAT + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
